// File: rtl/pci_pkg.sv
// ------------------------------------------------------------------
// pci_pkg : shared commands, FSM encoding and byte-enable constants
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package pci_pkg;

  typedef enum logic [3:0] {
    IO_READ   = 4'b0010,
    IO_WRITE  = 4'b0011,
    MEM_READ  = 4'b0110,
    MEM_WRITE = 4'b0111,
    CFG_READ  = 4'b1010,
    CFG_WRITE = 4'b1011
  } pci_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ABORT = 3'd3,
    ST_TURN  = 3'd4
  } init_state_e;

  localparam logic [3:0] BE_ALL  = 4'h0;
  localparam logic [3:0] BE_IDLE = 4'hF;

endpackage

`default_nettype wire

// File: rtl/pci_wbuf.sv
// ------------------------------------------------------------------
// pci_wbuf : one-entry write holding buffer control (data lives on AD_out)
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module pci_wbuf
  import pci_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clear,
  input  logic             enable,
  input  logic [LEN_W-1:0] len,
  input  logic             wdata_valid,
  input  logic             cmpl,
  output logic             wdata_ready,
  output logic             load,
  output logic             full_nxt
);

  logic             r_full;
  logic [LEN_W-1:0] r_fetched;

  // A beat may be taken into a slot that is being vacated this clock.
  assign wdata_ready = enable && (r_fetched < len) && (!r_full || cmpl);
  assign load        = wdata_ready && wdata_valid;
  assign full_nxt    = load || (r_full && !cmpl);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_full    <= 1'b0;
      r_fetched <= '0;
    end else if (clear) begin
      r_full    <= 1'b0;
      r_fetched <= '0;
    end else begin
      r_full    <= full_nxt;
      r_fetched <= r_fetched + LEN_W'(load);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pci_initiator.sv
// ------------------------------------------------------------------
// pci_initiator : PCI bus master turning local bursts into PCI phases
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 8,
  parameter int LEN_W          = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             GNT_,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [3:0]       req_be,
  input  logic [31:0]      wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             abort,
  output logic             FRAME_,
  output logic             IRDY_,
  output logic [3:0]       C_BE_,
  output logic [31:0]      AD_out,
  output logic             AD_oe,
  input  logic [31:0]      AD_in,
  input  logic             DEVSEL_,
  input  logic             TRDY_
);

  localparam int               TMO_W = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

  init_state_e      r_state;
  logic             r_write;
  logic [3:0]       r_be;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remain;
  logic [TMO_W-1:0] r_tmo;
  logic             r_claimed;

  logic             w_accept;
  logic             w_cmpl;
  logic             w_last;
  logic             w_tmo_fire;
  logic             w_load;
  logic             w_full_nxt;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_remain_nxt;

  assign req_ready = reset_ && (r_state == ST_IDLE) && !GNT_;
  assign w_accept  = req_valid && req_ready;

  // Out-of-range lengths degrade to a single data phase.
  assign w_len_eff = ((req_len == '0) || (req_len > LEN_W'(MAX_BURST))) ? c_one : req_len;

  assign w_cmpl       = (r_state == ST_DATA) && !IRDY_ && !TRDY_;
  assign w_remain_nxt = r_remain - LEN_W'(w_cmpl);
  assign w_last       = w_cmpl && (r_remain == c_one);
  assign w_tmo_fire   = (r_state == ST_DATA) && !r_claimed && DEVSEL_ &&
                        (r_tmo == TMO_W'(DEVSEL_TIMEOUT - 1));

  pci_wbuf #(
    .LEN_W (LEN_W)
  ) u_wbuf (
    .clk         (clk),
    .reset_      (reset_),
    .clear       (w_accept),
    .enable      ((r_state == ST_DATA) && r_write && !w_tmo_fire),
    .len         (r_len),
    .wdata_valid (wdata_valid),
    .cmpl        (w_cmpl),
    .wdata_ready (wdata_ready),
    .load        (w_load),
    .full_nxt    (w_full_nxt)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_be        <= BE_IDLE;
      r_len       <= '0;
      r_remain    <= '0;
      r_tmo       <= '0;
      r_claimed   <= 1'b0;
      FRAME_      <= 1'b1;
      IRDY_       <= 1'b1;
      C_BE_       <= BE_IDLE;
      AD_out      <= '0;
      AD_oe       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_ADDR;
            r_write  <= req_cmd[0];
            r_be     <= req_be;
            r_len    <= w_len_eff;
            r_remain <= w_len_eff;
            FRAME_   <= 1'b0;
            IRDY_    <= 1'b1;
            C_BE_    <= req_cmd;
            AD_out   <= req_addr;
            AD_oe    <= 1'b1;
          end
        end
        ST_ADDR: begin
          r_state   <= ST_DATA;
          C_BE_     <= r_be;
          r_tmo     <= '0;
          r_claimed <= 1'b0;
          // Reads turn the AD bus around and are ready for data at once.
          if (!r_write) begin
            AD_oe  <= 1'b0;
            IRDY_  <= 1'b0;
            FRAME_ <= (r_remain == c_one);
          end
        end
        ST_DATA: begin
          if (!DEVSEL_)
            r_claimed <= 1'b1;
          else if (!r_claimed)
            r_tmo <= r_tmo + TMO_W'(1);
          if (w_cmpl)
            r_remain <= w_remain_nxt;
          if (!r_write && w_cmpl) begin
            rdata       <= AD_in;
            rdata_valid <= 1'b1;
          end
          if (w_load)
            AD_out <= wdata;
          if (w_last) begin
            r_state <= ST_TURN;
            FRAME_  <= 1'b1;
            IRDY_   <= 1'b1;
            AD_oe   <= 1'b0;
            C_BE_   <= BE_IDLE;
            done    <= 1'b1;
          end else if (w_tmo_fire) begin
            r_state <= ST_ABORT;
            FRAME_  <= 1'b1;
            IRDY_   <= 1'b0;
          end else if (r_write) begin
            // FRAME_ may only rise once the final beat is held on the bus.
            IRDY_  <= !w_full_nxt;
            FRAME_ <= w_full_nxt && (w_remain_nxt == c_one);
          end else begin
            IRDY_  <= 1'b0;
            FRAME_ <= (w_remain_nxt == c_one);
          end
        end
        ST_ABORT: begin
          r_state <= ST_TURN;
          FRAME_  <= 1'b1;
          IRDY_   <= 1'b1;
          AD_oe   <= 1'b0;
          C_BE_   <= BE_IDLE;
          abort   <= 1'b1;
        end
        ST_TURN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
